// File: rtl/logic_unit_reduce.sv
// Multi-mode serial reduction engine: folds a WIDTH-bit request CHUNK bits per
// cycle into OR/AND/XOR/legacy reductions plus a population count.
module logic_unit_reduce #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             req_vec,
    input  logic [1:0]                   op,
    input  logic                         valid,
    output logic                         ready,
    input  logic                         flush,
    output logic                         out,
    output logic [$clog2(WIDTH+1)-1:0]   ones_cnt,
    output logic                         done
);
    // state  | meaning
    // IDLE   | waiting for a request, ready high
    // BUSY   | folding chunk idx, ready low, valid ignored
    // DONE   | one-cycle done pulse; may accept the next request directly

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] vec_q;
    logic [1:0]       op_q;
    logic [IW-1:0]    idx;
    logic             or_acc, and_acc, xor_acc, or_rest;
    logic [CW-1:0]    cnt_acc;

    logic [CHUNK-1:0] chunk, chunk_rest;
    logic [CW-1:0]    chunk_pop;
    logic             last, accept;
    logic             or_f, and_f, xor_f, rest_f, out_f;
    logic [CW-1:0]    cnt_f;

    assign ready  = (state != S_BUSY);
    assign done   = (state == S_DONE);
    assign accept = valid && ready;
    assign last   = (idx == IW'(NCHUNK - 1));

    always_comb begin
        chunk     = vec_q[idx*CHUNK +: CHUNK];
        // the top vector bit lives in the top bit of the final chunk
        chunk_rest = last ? (chunk & ~(CHUNK'(1) << (CHUNK - 1))) : chunk;
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + CW'(chunk[i]);
        end
        or_f   = or_acc | (|chunk);
        and_f  = and_acc & (&chunk);
        xor_f  = xor_acc ^ (^chunk);
        rest_f = or_rest | (|chunk_rest);
        cnt_f  = cnt_acc + chunk_pop;
        case (op_q)
            2'b00:   out_f = or_f;
            2'b01:   out_f = and_f;
            2'b10:   out_f = xor_f;
            default: out_f = vec_q[WIDTH-1] & rest_f;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (valid) state_nxt = S_BUSY;
            S_BUSY: begin
                if (flush)     state_nxt = S_IDLE;
                else if (last) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = valid ? S_BUSY : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            op_q     <= '0;
            idx      <= '0;
            or_acc   <= 1'b0;
            and_acc  <= 1'b0;
            xor_acc  <= 1'b0;
            or_rest  <= 1'b0;
            cnt_acc  <= '0;
            out      <= 1'b0;
            ones_cnt <= '0;
        end else if (accept) begin
            vec_q   <= req_vec;
            op_q    <= op;
            idx     <= '0;
            or_acc  <= 1'b0;
            and_acc <= 1'b1;
            xor_acc <= 1'b0;
            or_rest <= 1'b0;
            cnt_acc <= '0;
        end else if (state == S_BUSY && !flush) begin
            or_acc  <= or_f;
            and_acc <= and_f;
            xor_acc <= xor_f;
            or_rest <= rest_f;
            cnt_acc <= cnt_f;
            if (last) begin
                out      <= out_f;
                ones_cnt <= cnt_f;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: doc/logic_unit_reduce.md
# logic_unit_reduce

Parametrised multi-mode serial reduction engine, the successor to the single-function sequential logic unit. It accepts a WIDTH-bit request vector through a valid/ready handshake and folds it CHUNK bits per cycle. It then returns a one-bit reduction result, selectable among OR, AND, XOR and the legacy "MSB AND OR-of-rest" function, together with a population count. It sits behind request-vector producers in the lab datapath and replaces the fixed-function unit wherever variable width or throughput is needed.

## Interface
- WIDTH, default 64: request vector width. Constraint: WIDTH >= 2.
- CHUNK, default 8: bits folded per cycle. Constraints: 1 <= CHUNK <= WIDTH, and WIDTH % CHUNK == 0.
- Derived values:
  - NCHUNK = WIDTH/CHUNK, the busy cycles per request.
  - CW = $clog2(WIDTH+1), the count width.
- clk, input, 1: the single clock. All flops are rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_vec, input, WIDTH: request vector, sampled on the accept edge only.
- op, input, 2: mode, sampled on the accept edge.
  - 00: OR-reduce.
  - 01: AND-reduce.
  - 10: XOR-reduce (parity).
  - 11: legacy function, req_vec[WIDTH-1] & |req_vec[WIDTH-2:0].
- valid, input, 1: request present.
- ready, output, 1: the block can accept. ready = (state != BUSY).
- flush, input, 1: synchronous abort of an in-flight request.
- out, output, 1: reduction result. Valid while done is high, and held until the next done.
- ones_cnt, output, CW: number of ones in the accepted vector. Updated together with out.
- done, output, 1: one-cycle pulse marking out and ones_cnt as valid.

## Operation
- States:
  - IDLE.
  - BUSY, which carries an index idx in 0..NCHUNK-1.
  - DONE, which lasts exactly one cycle.
- Accept: valid & ready at a rising edge. On the accept edge the block:
  - captures req_vec and op;
  - sets idx = 0;
  - initialises the accumulators: or_acc=0, and_acc=1, xor_acc=0, cnt_acc=0;
  - goes to BUSY.
- BUSY edge: fold chunk idx (bits [idx*CHUNK +: CHUNK]) into all four accumulators, then idx <= idx+1.
- Mode 11 bookkeeping: the OR term for mode 11 excludes bit WIDTH-1. A separate or_rest accumulator masks that bit during the last chunk.
- Final chunk (idx == NCHUNK-1):
  - registers out from the final fold, per the captured op;
  - registers ones_cnt from the final fold;
  - goes to DONE.
- DONE:
  - done = 1 and ready = 1.
  - If valid is high, the block accepts the new request (back-to-back) and goes to BUSY.
  - Otherwise it goes to IDLE.
- IDLE: done = 0, ready = 1.
- valid during BUSY is ignored. Nothing is queued; ready is low during BUSY.
- flush:
  - In BUSY: go to IDLE on the next edge with no done pulse. out and ones_cnt keep their previous values.
  - In IDLE or DONE: ignored. It does not suppress a DONE already entered.
- Simultaneous flush and accept in DONE: the accept wins.
- Arithmetic:
  - cnt_acc is CW bits and adds a per-chunk popcount of up to CHUNK.
  - The count cannot overflow; the maximum is WIDTH.
- Mode is latched at accept. Changes to op during BUSY have no effect.

## Timing
- Reset (rst_n low), asynchronous and immediate:
  - state=IDLE, so ready=1;
  - done=0, out=0, ones_cnt=0;
  - all accumulators cleared.
- Reset mid-operation abandons the request. No done is produced after release.
- Latency: accept on edge E0; chunks fold on E1..E(NCHUNK); done is high during the cycle after E(NCHUNK).
  - That is, done rises NCHUNK cycles after the accept edge.
- CHUNK == WIDTH: done rises one cycle after accept.
- Throughput: one request per NCHUNK+1 cycles with valid held high. A new accept in DONE makes the next done exactly NCHUNK+1 cycles after the previous one.
- done is never high for two consecutive cycles.

## Test plan
All scenarios use WIDTH=64, CHUNK=8, so NCHUNK=8.

- Reset: drive rst_n low 3 cycles into BUSY -> done/out/ones_cnt=0 and ready=1 immediately; no done after release.
- OR mode: op=00, vec=0x0000_0000_0000_0100 -> done 8 cycles after accept, out=1, ones_cnt=1.
  - vec=0 -> out=0, ones_cnt=0.
- AND mode: op=01, vec=0xFFFF_FFFF_FFFF_FFFF -> out=1, ones_cnt=64.
  - vec=0xFFFF_FFFF_FFFF_FFFE -> out=0, ones_cnt=63.
- XOR mode: op=10, vec=0x7 -> out=1, ones_cnt=3.
  - vec=0x8000_0000_0000_0001 -> out=0, ones_cnt=2.
- Legacy mode: op=11.
  - vec=0x8000_0000_0000_0000 -> out=0.
  - vec=0x8000_0000_0000_0001 -> out=1.
  - vec=0x7FFF_FFFF_FFFF_FFFF -> out=0.
- Handshake:
  - valid held with a new vec/op during DONE -> accepted, second done 9 cycles after the first.
  - valid pulsed during BUSY -> ignored.
  - flush at idx=4 -> IDLE, no done, out/ones_cnt unchanged.
